// File: rtl/spi_slave_core_if.sv
// ============================================================================
// Module   : spi_slave_core_if
// Brief    : SPI pins plus local TX/RX valid-ready handshake for spi_slave_core.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface spi_slave_core_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  sclk;
  logic                  mosi;
  logic                  cs;
  logic                  miso;
  logic                  miso_oe;
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_valid;
  logic                  tx_ready;
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_valid;
  logic                  rx_ready;
  logic                  busy;
  logic                  tx_underrun;
  logic                  rx_overrun;

  modport slave (
    input  sclk, mosi, cs, tx_data, tx_valid, rx_ready,
    output miso, miso_oe, tx_ready, rx_data, rx_valid, busy, tx_underrun, rx_overrun
  );

  modport master (
    output sclk, mosi, cs, tx_data, tx_valid, rx_ready,
    input  miso, miso_oe, tx_ready, rx_data, rx_valid, busy, tx_underrun, rx_overrun
  );
endinterface

`default_nettype wire

// File: rtl/spi_slave_core.sv
// ============================================================================
// Module   : spi_slave_core
// Brief    : SPI mode-0 slave, fully in the ACLK domain (oversampled SCLK/CS).
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module spi_slave_core #(
  parameter int                    DATA_WIDTH  = 8,
  parameter int                    SYNC_STAGES = 2,
  parameter logic [DATA_WIDTH-1:0] DEFAULT_TX  = '0
) (
  input  wire logic        ACLK,
  input  wire logic        ARESETN,
  spi_slave_core_if.slave  bus
);

  localparam int                 CNT_W  = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0]   C_LAST = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

  // ---------------------------------------------------------------- sync
  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic [SYNC_STAGES-1:0] r_cs_sync;
  logic                   r_sclk_hist;
  logic                   r_cs_hist;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_sclk_sync <= '0;
      r_mosi_sync <= '0;
      r_cs_sync   <= '1;
      r_sclk_hist <= 1'b0;
      r_cs_hist   <= 1'b1;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], bus.sclk};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], bus.mosi};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], bus.cs};
      r_sclk_hist <= r_sclk_sync[SYNC_STAGES-1];
      r_cs_hist   <= r_cs_sync[SYNC_STAGES-1];
    end
  end

  logic w_sclk_s, w_mosi_s, w_cs_s;
  logic w_sclk_rise, w_sclk_fall, w_cs_fall, w_cs_rise;

  assign w_sclk_s    = r_sclk_sync[SYNC_STAGES-1];
  assign w_mosi_s    = r_mosi_sync[SYNC_STAGES-1];
  assign w_cs_s      = r_cs_sync[SYNC_STAGES-1];
  assign w_sclk_rise =  w_sclk_s & ~r_sclk_hist;
  assign w_sclk_fall = ~w_sclk_s &  r_sclk_hist;
  assign w_cs_fall   = ~w_cs_s   &  r_cs_hist;
  assign w_cs_rise   =  w_cs_s   & ~r_cs_hist;

  // ---------------------------------------------------------------- state
  state_t                  r_state;
  logic                    r_busy;
  logic                    r_miso_oe;
  logic [CNT_W-1:0]        r_bit_cnt;
  logic [DATA_WIDTH-1:0]   r_tx_shift;
  logic [DATA_WIDTH-2:0]   r_rx_shift;
  logic [DATA_WIDTH-1:0]   r_rx_data;
  logic                    r_rx_valid;
  logic                    r_tx_underrun;
  logic                    r_rx_overrun;
  logic                    r_underrun_pend;
  logic [DATA_WIDTH-1:0]   r_hold;
  logic                    r_hold_full;

  logic                    w_active;
  logic                    w_reload;
  logic                    w_tx_accept;
  logic [DATA_WIDTH-1:0]   w_rx_next;

  assign w_active    = (r_state == ST_ACTIVE) & ~w_cs_rise;
  assign w_reload    = ((r_state == ST_IDLE) & w_cs_fall)
                     | (w_active & w_sclk_fall & (r_bit_cnt == '0));
  assign w_tx_accept = bus.tx_valid & ~r_hold_full;
  assign w_rx_next   = {r_rx_shift, w_mosi_s};

  // Reload samples the pre-load holding state, so a same-cycle load is kept.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_hold      <= '0;
      r_hold_full <= 1'b0;
    end else if (w_reload && r_hold_full) begin
      r_hold_full <= 1'b0;
    end else if (w_tx_accept) begin
      r_hold      <= bus.tx_data;
      r_hold_full <= 1'b1;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_state         <= ST_IDLE;
      r_busy          <= 1'b0;
      r_miso_oe       <= 1'b0;
      r_bit_cnt       <= '0;
      r_tx_shift      <= '0;
      r_rx_shift      <= '0;
      r_rx_data       <= '0;
      r_rx_valid      <= 1'b0;
      r_tx_underrun   <= 1'b0;
      r_rx_overrun    <= 1'b0;
      r_underrun_pend <= 1'b0;
    end else begin
      r_tx_underrun <= 1'b0;
      r_rx_overrun  <= 1'b0;
      if (r_rx_valid && bus.rx_ready) begin
        r_rx_valid <= 1'b0;
      end

      case (r_state)
        ST_IDLE: begin
          if (w_cs_fall) begin
            r_state    <= ST_ACTIVE;
            r_busy     <= 1'b1;
            r_miso_oe  <= 1'b1;
            r_bit_cnt  <= '0;
            r_rx_shift <= '0;
            if (r_hold_full) begin
              r_tx_shift <= r_hold;
            end else begin
              r_tx_shift    <= DEFAULT_TX;
              r_tx_underrun <= 1'b1;
            end
          end
        end

        ST_ACTIVE: begin
          if (w_cs_rise) begin
            r_state         <= ST_IDLE;
            r_busy          <= 1'b0;
            r_miso_oe       <= 1'b0;
            r_bit_cnt       <= '0;
            r_tx_shift      <= '0;
            r_rx_shift      <= '0;
            r_underrun_pend <= 1'b0;
          end else begin
            if (w_sclk_rise) begin
              r_rx_shift <= w_rx_next[DATA_WIDTH-2:0];
              if (r_bit_cnt == C_LAST) begin
                r_bit_cnt  <= '0;
                r_rx_data  <= w_rx_next;
                r_rx_valid <= 1'b1;
                if (r_rx_valid && !bus.rx_ready) begin
                  r_rx_overrun <= 1'b1;
                end
              end else begin
                r_bit_cnt <= r_bit_cnt + 1'b1;
              end
              // An empty boundary reload is only an underrun once the word really starts;
              // the trailing SCLK fall at frame end must not flag one.
              if (r_underrun_pend) begin
                r_tx_underrun   <= 1'b1;
                r_underrun_pend <= 1'b0;
              end
            end

            if (w_sclk_fall) begin
              if (r_bit_cnt == '0) begin
                if (r_hold_full) begin
                  r_tx_shift <= r_hold;
                end else begin
                  r_tx_shift      <= DEFAULT_TX;
                  r_underrun_pend <= 1'b1;
                end
              end else begin
                r_tx_shift <= r_tx_shift << 1;
              end
            end
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.miso        = r_tx_shift[DATA_WIDTH-1];
  assign bus.miso_oe     = r_miso_oe;
  assign bus.tx_ready    = ~r_hold_full;
  assign bus.rx_data     = r_rx_data;
  assign bus.rx_valid    = r_rx_valid;
  assign bus.busy        = r_busy;
  assign bus.tx_underrun = r_tx_underrun;
  assign bus.rx_overrun  = r_rx_overrun;

endmodule

`default_nettype wire

// File: tb/tb_spi_slave_core.sv
// ============================================================================
// Module   : tb_spi_slave_core
// Brief    : Directed bench: bit-banged mode-0 master (8-ACLK SCLK) vs slave.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_spi_slave_core;

  localparam int W = 8;

  logic ACLK    = 1'b0;
  logic ARESETN = 1'b0;

  spi_slave_core_if #(.DATA_WIDTH(W)) bus ();

  spi_slave_core #(
    .DATA_WIDTH (W),
    .SYNC_STAGES(2),
    .DEFAULT_TX (8'h00)
  ) dut (
    .ACLK   (ACLK),
    .ARESETN(ARESETN),
    .bus    (bus)
  );

  always #5 ACLK = ~ACLK;

  int checks    = 0;
  int errors    = 0;
  int underruns = 0;
  int overruns  = 0;

  always @(negedge ACLK) begin
    if (bus.tx_underrun) underruns++;
    if (bus.rx_overrun)  overruns++;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge ACLK);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Master drives MOSI at the start of the low phase and samples MISO just before SCLK rises.
  task automatic xfer_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = '0;
    for (int i = 7; i >= 8 - nbits; i--) begin
      bus.mosi = tx[i];
      tick(4);
      rx[i] = bus.miso;
      bus.sclk = 1'b1;
      tick(4);
      bus.sclk = 1'b0;
    end
  endtask

  task automatic cs_low();
    bus.cs = 1'b0;
    tick(5);
  endtask

  task automatic cs_high();
    tick(4);
    bus.cs = 1'b1;
    tick(6);
  endtask

  task automatic load_tx(input logic [7:0] d);
    bus.tx_data  = d;
    bus.tx_valid = 1'b1;
    tick(1);
    bus.tx_valid = 1'b0;
  endtask

  task automatic consume();
    bus.rx_ready = 1'b1;
    tick(1);
    bus.rx_ready = 1'b0;
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_miso"},     32'(bus.miso),        32'h0);
    check({pfx, "_miso_oe"},  32'(bus.miso_oe),     32'h0);
    check({pfx, "_tx_ready"}, 32'(bus.tx_ready),    32'h1);
    check({pfx, "_rx_data"},  32'(bus.rx_data),     32'h0);
    check({pfx, "_rx_valid"}, 32'(bus.rx_valid),    32'h0);
    check({pfx, "_busy"},     32'(bus.busy),        32'h0);
    check({pfx, "_underrun"}, 32'(bus.tx_underrun), 32'h0);
    check({pfx, "_overrun"},  32'(bus.rx_overrun),  32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] r;
    logic [7:0] r2;
    int u0;
    int o0;

    bus.sclk     = 1'b0;
    bus.mosi     = 1'b0;
    bus.cs       = 1'b1;
    bus.tx_data  = '0;
    bus.tx_valid = 1'b0;
    bus.rx_ready = 1'b0;
    tick(3);
    check_reset_outputs("reset");
    ARESETN = 1'b1;
    tick(4);

    // Single word with a preloaded reply.
    u0 = underruns; o0 = overruns;
    load_tx(8'hA5);
    check("t1_tx_full", 32'(bus.tx_ready), 32'h0);
    cs_low();
    check("t1_busy",    32'(bus.busy),     32'h1);
    check("t1_miso_oe", 32'(bus.miso_oe),  32'h1);
    check("t1_tx_emptied", 32'(bus.tx_ready), 32'h1);
    check("t1_miso_msb", 32'(bus.miso),    32'h1);
    xfer_bits(8'h3C, 8, r);
    check("t1_master_rx", 32'(r),            32'hA5);
    check("t1_rx_valid",  32'(bus.rx_valid), 32'h1);
    check("t1_rx_data",   32'(bus.rx_data),  32'h3C);
    cs_high();
    check("t1_idle_busy", 32'(bus.busy),    32'h0);
    check("t1_idle_oe",   32'(bus.miso_oe), 32'h0);
    consume();
    check("t1_rx_cleared", 32'(bus.rx_valid), 32'h0);
    check("t1_underruns", 32'(underruns - u0), 32'h0);
    check("t1_overruns",  32'(overruns - o0),  32'h0);

    // Two back-to-back words under continuous CS.
    u0 = underruns; o0 = overruns;
    load_tx(8'h11);
    cs_low();
    load_tx(8'h22);
    check("t2_hold_full", 32'(bus.tx_ready), 32'h0);
    xfer_bits(8'hC3, 8, r);
    check("t2_master_rx0", 32'(r),            32'h11);
    check("t2_rx_data0",   32'(bus.rx_data),  32'hC3);
    check("t2_rx_valid0",  32'(bus.rx_valid), 32'h1);
    consume();
    check("t2_rx_clear0",  32'(bus.rx_valid), 32'h0);
    xfer_bits(8'h5A, 8, r);
    check("t2_master_rx1", 32'(r),            32'h22);
    check("t2_rx_data1",   32'(bus.rx_data),  32'h5A);
    consume();
    cs_high();
    check("t2_underruns", 32'(underruns - u0), 32'h0);
    check("t2_overruns",  32'(overruns - o0),  32'h0);

    // Empty holding register: default word and one underrun at CS fall.
    u0 = underruns;
    cs_low();
    check("t3_underrun_at_cs", 32'(underruns - u0), 32'h1);
    xfer_bits(8'hFF, 8, r);
    cs_high();
    check("t3_master_rx", 32'(r),               32'h00);
    check("t3_underruns", 32'(underruns - u0),  32'h1);
    check("t3_rx_data",   32'(bus.rx_data),     32'hFF);
    consume();

    // Unread word overwritten by the next one.
    u0 = underruns; o0 = overruns;
    cs_low();
    xfer_bits(8'h01, 8, r);
    check("t4_no_overrun_yet", 32'(overruns - o0), 32'h0);
    xfer_bits(8'h02, 8, r2);
    check("t4_master_rx", 32'(r2),            32'h00);
    check("t4_rx_data",   32'(bus.rx_data),  32'h02);
    check("t4_rx_valid",  32'(bus.rx_valid), 32'h1);
    cs_high();
    check("t4_overruns",  32'(overruns - o0),  32'h1);
    check("t4_underruns", 32'(underruns - u0), 32'h2);
    consume();

    // Frame aborted after four bits, then a clean frame.
    cs_low();
    xfer_bits(8'hF0, 4, r);
    cs_high();
    check("t5_no_rx_valid", 32'(bus.rx_valid), 32'h0);
    check("t5_busy",        32'(bus.busy),     32'h0);
    check("t5_miso_oe",     32'(bus.miso_oe),  32'h0);
    check("t5_rx_data_kept", 32'(bus.rx_data), 32'h02);
    cs_low();
    xfer_bits(8'h81, 8, r);
    cs_high();
    check("t5_rx_data",  32'(bus.rx_data),  32'h81);
    check("t5_rx_valid", 32'(bus.rx_valid), 32'h1);

    // Asynchronous reset in the middle of a word (0x81 left unread on purpose).
    cs_low();
    load_tx(8'h77);
    check("t6_hold_full", 32'(bus.tx_ready), 32'h0);
    xfer_bits(8'hA5, 3, r);
    bus.sclk = 1'b1;
    tick(2);
    ARESETN = 1'b0;
    #1;
    check_reset_outputs("t6_async");
    bus.sclk = 1'b0;
    bus.cs   = 1'b1;
    tick(3);
    ARESETN = 1'b1;
    tick(4);
    load_tx(8'h5A);
    cs_low();
    xfer_bits(8'hA5, 8, r);
    cs_high();
    check("t6_master_rx", 32'(r),            32'h5A);
    check("t6_rx_data",   32'(bus.rx_data),  32'hA5);
    check("t6_rx_valid",  32'(bus.rx_valid), 32'h1);
    consume();
    check("t6_rx_cleared", 32'(bus.rx_valid), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
